// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC calibration hit generator: FSM encodings and
// the default acknowledge timeout.
package tdc_pkg;

  typedef enum logic [2:0] {
    HG_IDLE,
    HG_PULSE,
    HG_WAIT_ACK,
    HG_GAP,
    HG_DONE
  } hg_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/tdc_ack_timer.sv
// Loadable down-counter for the hit acknowledge timeout. Expire fires on the
// TIMEOUT-th enabled cycle after a load.
module tdc_ack_timer
  import tdc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign expire = en && (cnt == TW'(1));

endmodule

// File: rtl/tdc_hit_generator.sv
// Calibration hit source for the TDC stop path: programmable glitch-free hit
// bursts, each hit held off until finish returns or the ack timer expires.
module tdc_hit_generator
  import tdc_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PW_W    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] n_hits,
  input  logic [PW_W-1:0]  pulse_width,
  input  logic             finish,
  output logic             hit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits_sent,
  output logic             timeout_err
);

  function automatic logic [PW_W-1:0] pw_effective(input logic [PW_W-1:0] pw);
    return (pw == '0) ? PW_W'(1) : pw;
  endfunction

  // Guarantees at least two low cycles between hits.
  function automatic logic [CNT_W-1:0] eff_period_calc(input logic [CNT_W-1:0] p,
                                                       input logic [PW_W-1:0]  pwe);
    logic [CNT_W-1:0] lo;
    lo = CNT_W'(pwe) + CNT_W'(2);
    return (p > lo) ? p : lo;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  hg_state_t        state;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] eff_q;
  logic [CNT_W-1:0] n_q;
  logic [PW_W-1:0]  pw_q;
  logic             expire;
  logic             accept;
  logic             pulse_end;
  logic             gap_end;
  logic [CNT_W-1:0] hits_next;
  logic             last_hit;

  assign accept    = (state == HG_IDLE) && start && !stop;
  assign pulse_end = pcnt >= CNT_W'(pw_q - PW_W'(1));
  assign gap_end   = pcnt >= (eff_q - CNT_W'(1));
  assign hits_next = sat_inc(hits_sent);
  assign last_hit  = (n_q != '0) && (hits_next == n_q);

  tdc_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state != HG_WAIT_ACK),
    .en     (state == HG_WAIT_ACK),
    .expire (expire)
  );

  // Burst configuration is captured once per accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      pw_q  <= pw_effective(pulse_width);
      eff_q <= eff_period_calc(period, pw_effective(pulse_width));
      n_q   <= n_hits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HG_IDLE;
      hit         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hits_sent   <= '0;
      timeout_err <= 1'b0;
      pcnt        <= '0;
    end else begin
      pcnt <= sat_inc(pcnt);
      done <= 1'b0;
      case (state)
        HG_IDLE: begin
          if (accept) begin
            state       <= HG_PULSE;
            hit         <= 1'b1;
            busy        <= 1'b1;
            hits_sent   <= '0;
            timeout_err <= 1'b0;
            pcnt        <= '0;
          end
        end
        HG_PULSE: begin
          if (stop) begin
            state <= HG_DONE;
            hit   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (pulse_end) begin
            state <= HG_WAIT_ACK;
            hit   <= 1'b0;
          end
        end
        HG_WAIT_ACK: begin
          if (stop) begin
            state <= HG_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (finish || expire) begin
            hits_sent <= hits_next;
            if (!finish) timeout_err <= 1'b1;
            if (last_hit) begin
              state <= HG_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= HG_GAP;
            end
          end
        end
        HG_GAP: begin
          if (stop) begin
            state <= HG_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_end) begin
            state <= HG_PULSE;
            hit   <= 1'b1;
            pcnt  <= '0;
          end
        end
        HG_DONE: begin
          state <= HG_IDLE;
        end
        default: begin
          state <= HG_IDLE;
          hit   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
